key_conditioner: RTL and testbench

//   Receiving end of the board push-button interface: takes the raw active-low KEY bus, synchronises it to

---
 rtl/key_cond_pkg.sv | 14 +
 rtl/key_debounce_ch.sv | 104 ++++++++++
 rtl/key_conditioner.sv | 33 +++
 tb/tb_key_conditioner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and default constants for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned KEY_SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned KEY_DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage : key_cond_pkg

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce FSM with stability counter,
// registered press/release pulses and an 8-bit accepted-press counter.
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = KEY_SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ks;

  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, press_nxt, release_nxt;
  logic [7:0]    count_nxt;

  // Synchroniser chain; resets to the released (high) level of the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], key_n};
  end

  assign ks = ~sync[SYNC_STAGES-1];

  // State, stability counter, level, pulses and press counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      press_count   <= count_nxt;
    end
  end

  // Next-state and output logic; pulses default low so they last one cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    count_nxt   = press_count;
    unique case (state)
      RELEASED: begin
        if (ks) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!ks) begin
          state_nxt = RELEASED;
        end else if (cnt == LAST) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          count_nxt = press_count + 8'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!ks) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (ks) begin
          state_nxt = PRESSED;
        end else if (cnt == LAST) begin
          state_nxt   = RELEASED;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end

endmodule : key_debounce_ch

// File: rtl/key_conditioner.sv
// Push-button conditioner: one independent debounce channel per KEY pin.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned SYNC_STAGES     = KEY_SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   KEY,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [NUM_KEYS*8-1:0] press_cnt
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (CLOCK_50),
      .rst_n        (rst_n),
      .key_n        (KEY[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i]),
      .press_count  (press_cnt[8*i +: 8])
    );
  end

endmodule : key_conditioner

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
// (press/release pulse 7 edges after the first edge sampling a new KEY value).
module tb_key_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key;
  logic [3:0]  key_level, key_press, key_release;
  logic [31:0] press_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS       (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .KEY        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .press_cnt  (press_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_p;
    rst_n = 1'b0;
    key   = 4'b0000;
    step();
    step();
    n_checks++; if (key_level !== 4'h0) begin n_fail++; $display("FAIL reset_level: got %h want %h", key_level, 4'h0); end
    n_checks++; if (key_press !== 4'h0) begin n_fail++; $display("FAIL reset_press: got %h want %h", key_press, 4'h0); end
    n_checks++; if (key_release !== 4'h0) begin n_fail++; $display("FAIL reset_release: got %h want %h", key_release, 4'h0); end
    n_checks++; if (press_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want %h", press_cnt, 32'h0); end
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp_p = (c == 7) ? 4'hF : 4'h0;
      n_checks++; if (key_press !== exp_p) begin n_fail++; $display("FAIL held_press c%0d: got %h want %h", c, key_press, exp_p); end
      n_checks++; if (key_release !== 4'h0) begin n_fail++; $display("FAIL held_release c%0d: got %h want 0", c, key_release); end
    end
    n_checks++; if (key_level !== 4'hF) begin n_fail++; $display("FAIL held_level: got %h want %h", key_level, 4'hF); end
    n_checks++; if (press_cnt !== 32'h01010101) begin n_fail++; $display("FAIL held_cnt: got %h want %h", press_cnt, 32'h01010101); end
    key = 4'hF;
    for (int c = 1; c <= 12; c++) step();
    n_checks++; if (key_level !== 4'h0) begin n_fail++; $display("FAIL held_rel_level: got %h want 0", key_level); end
    n_checks++; if (press_cnt !== 32'h01010101) begin n_fail++; $display("FAIL held_rel_cnt: got %h want %h", press_cnt, 32'h01010101); end
  endtask

  task automatic test_clean_press();
    logic exp_b;
    key[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_b = (c == 7);
      n_checks++; if (key_press[0] !== exp_b) begin n_fail++; $display("FAIL clean_press c%0d: got %b want %b", c, key_press[0], exp_b); end
      n_checks++; if (key_release[0] !== 1'b0) begin n_fail++; $display("FAIL clean_press_rel c%0d: got %b want 0", c, key_release[0]); end
      exp_b = (c >= 7);
      n_checks++; if (key_level[0] !== exp_b) begin n_fail++; $display("FAIL clean_level_up c%0d: got %b want %b", c, key_level[0], exp_b); end
    end
    key[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_b = (c == 7);
      n_checks++; if (key_release[0] !== exp_b) begin n_fail++; $display("FAIL clean_release c%0d: got %b want %b", c, key_release[0], exp_b); end
      n_checks++; if (key_press[0] !== 1'b0) begin n_fail++; $display("FAIL clean_rel_press c%0d: got %b want 0", c, key_press[0]); end
      exp_b = (c < 7);
      n_checks++; if (key_level[0] !== exp_b) begin n_fail++; $display("FAIL clean_level_dn c%0d: got %b want %b", c, key_level[0], exp_b); end
    end
    n_checks++; if (press_cnt[7:0] !== 8'h02) begin n_fail++; $display("FAIL clean_cnt: got %h want %h", press_cnt[7:0], 8'h02); end
  endtask

  task automatic test_bounce();
    int presses = 0;
    int releases = 0;
    int press_at = -1;
    for (int c = 1; c <= 34; c++) begin
      key[1] = (c == 4 || c > 14) ? 1'b1 : 1'b0;
      step();
      if (key_press[1] === 1'b1) begin presses++; press_at = c; end
      if (key_release[1] === 1'b1) releases++;
      n_checks++; if ((key_press[1] & key_release[1]) !== 1'b0) begin n_fail++; $display("FAIL bounce_coincide c%0d: got 1 want 0", c); end
    end
    n_checks++; if (presses != 1) begin n_fail++; $display("FAIL bounce_presses: got %0d want 1", presses); end
    n_checks++; if (press_at != 11) begin n_fail++; $display("FAIL bounce_press_cycle: got %0d want 11", press_at); end
    n_checks++; if (releases != 1) begin n_fail++; $display("FAIL bounce_releases: got %0d want 1", releases); end
    n_checks++; if (press_cnt[15:8] !== 8'h02) begin n_fail++; $display("FAIL bounce_cnt: got %h want %h", press_cnt[15:8], 8'h02); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      key[2] = (c <= 2) ? 1'b0 : 1'b1;
      step();
      if (key_press[2] === 1'b1 || key_release[2] === 1'b1) pulses++;
      n_checks++; if (key_level[2] !== 1'b0) begin n_fail++; $display("FAIL glitch_level c%0d: got %b want 0", c, key_level[2]); end
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
    n_checks++; if (press_cnt[23:16] !== 8'h01) begin n_fail++; $display("FAIL glitch_cnt: got %h want %h", press_cnt[23:16], 8'h01); end
  endtask

  task automatic test_wrap();
    int presses = 0;
    key   = 4'hF;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    n_checks++; if (press_cnt !== 32'h0) begin n_fail++; $display("FAIL wrap_start_cnt: got %h want 0", press_cnt); end
    for (int i = 0; i < 256; i++) begin
      key[3] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        step();
        if (key_press[3] === 1'b1) presses++;
      end
      key[3] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        step();
        if (key_press[3] === 1'b1) presses++;
      end
      if (i == 254) begin
        n_checks++; if (press_cnt[31:24] !== 8'hFF) begin n_fail++; $display("FAIL wrap_cnt_255: got %h want %h", press_cnt[31:24], 8'hFF); end
      end
    end
    n_checks++; if (presses != 256) begin n_fail++; $display("FAIL wrap_presses: got %0d want 256", presses); end
    n_checks++; if (press_cnt !== 32'h0) begin n_fail++; $display("FAIL wrap_cnt: got %h want %h", press_cnt, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic exp_b;
    key[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++; if (key_press[0] !== 1'b0) begin n_fail++; $display("FAIL mid_early_press c%0d: got %b want 0", c, key_press[0]); end
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({key_level, key_press, key_release} !== 12'h0) begin n_fail++; $display("FAIL mid_async_outs: got %h want 0", {key_level, key_press, key_release}); end
    step();
    step();
    n_checks++; if (press_cnt !== 32'h0) begin n_fail++; $display("FAIL mid_reset_cnt: got %h want 0", press_cnt); end
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp_b = (c == 7);
      n_checks++; if (key_press[0] !== exp_b) begin n_fail++; $display("FAIL mid_press c%0d: got %b want %b", c, key_press[0], exp_b); end
    end
    n_checks++; if (press_cnt[7:0] !== 8'h01) begin n_fail++; $display("FAIL mid_cnt: got %h want %h", press_cnt[7:0], 8'h01); end
    n_checks++; if (key_level !== 4'h1) begin n_fail++; $display("FAIL mid_level: got %h want %h", key_level, 4'h1); end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_key_conditioner
